// File: rtl/csa_pkg.sv
// Shared types and width helpers for the carry-save multi-operand accumulator.
package csa_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } csa_ctrl_state_t;

   // Accumulator width that holds MAX_OPS operands of n bits without wrapping.
   function automatic int unsigned csa_acc_width(input int unsigned n, input int unsigned max_ops);
      return n + $clog2(max_ops);
   endfunction

endpackage

// File: rtl/csa32_compress.sv
// Bitwise 3:2 compressor: sum bits and majority carries shifted up one place.
module csa32_compress #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   output logic [W-1:0] s_o,
   output logic [W-1:0] cy_o
);

   assign s_o  = a_i ^ b_i ^ c_i;
   assign cy_o = ((a_i & b_i) | (a_i & c_i) | (b_i & c_i)) << 1;

endmodule

// File: rtl/csa_accum_ctrl.sv
// Multi-operand adder sequencer: carry-save accumulation of a streamed operand group,
// then a chunked carry-propagate resolve into a held binary result.
module csa_accum_ctrl
   import csa_pkg::*;
#(
   parameter int unsigned N       = 5,
   parameter int unsigned MAX_OPS = 8,
   parameter int unsigned CHUNK   = 4,
   localparam int unsigned W      = csa_acc_width(N, MAX_OPS),
   localparam int unsigned CW     = $clog2(MAX_OPS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_sum,
   output logic [CW-1:0] out_count,
   output logic          out_ovf,
   output logic          busy
);

   localparam int unsigned NCHUNK = (W + CHUNK - 1) / CHUNK;
   localparam int unsigned WP     = NCHUNK * CHUNK;
   localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int unsigned SW     = CHUNK + 1;
   localparam logic [CHUNK-1:0] CMASK = '1;

   csa_ctrl_state_t state_q, state_d;

   logic [W-1:0]  s_q, s_d, c_q, c_d;
   logic [WP-1:0] r_q, r_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_out_q, cnt_out_d;
   logic          ovf_q, ovf_d, ovf_out_q, ovf_out_d;
   logic          cy_q, cy_d;
   logic [KW-1:0] k_q, k_d;

   logic             accept_c;
   logic             last_chunk_c;
   logic             cy_in_c;
   logic [W-1:0]     x_c, cs_s_c, cs_c_c;
   logic [31:0]      sh_c;
   logic [CHUNK-1:0] s_sl_c, c_sl_c;
   logic [SW-1:0]    slice_sum_c;

   csa32_compress #(.W(W)) u_compress (
      .a_i  (s_q),
      .b_i  (c_q),
      .c_i  (x_c),
      .s_o  (cs_s_c),
      .cy_o (cs_c_c)
   );

   assign x_c          = W'(in_data);
   assign accept_c     = in_valid && in_ready;
   assign last_chunk_c = (k_q == KW'(NCHUNK - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept_c) state_d = in_last ? RESOLVE : ACCUM;
         ACCUM:   if (accept_c && in_last) state_d = RESOLVE;
         RESOLVE: if (last_chunk_c) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the registered state only
   always_comb begin
      in_ready  = (state_q == IDLE) || (state_q == ACCUM);
      busy      = (state_q != IDLE);
      out_valid = (state_q == DONE);
   end

   // Current resolve slice; the first slice takes no carry-in
   always_comb begin
      sh_c        = 32'(k_q) * CHUNK;
      cy_in_c     = (k_q == '0) ? 1'b0 : cy_q;
      s_sl_c      = CHUNK'(WP'(s_q) >> sh_c);
      c_sl_c      = CHUNK'(WP'(c_q) >> sh_c);
      slice_sum_c = SW'(s_sl_c) + SW'(c_sl_c) + SW'(cy_in_c);
   end

   // Datapath next-state
   always_comb begin
      s_d       = s_q;
      c_d       = c_q;
      r_d       = r_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      cnt_out_d = cnt_out_q;
      ovf_out_d = ovf_out_q;
      cy_d      = cy_q;
      k_d       = k_q;
      unique case (state_q)
         IDLE: begin
            if (accept_c) begin
               s_d   = x_c;
               c_d   = '0;
               cnt_d = CW'(1);
               ovf_d = 1'b0;
               k_d   = '0;
            end
         end
         ACCUM: begin
            if (accept_c) begin
               s_d = cs_s_c;
               c_d = cs_c_c;
               k_d = '0;
               if (cnt_q == CW'(MAX_OPS)) ovf_d = 1'b1;
               else                       cnt_d = cnt_q + CW'(1);
            end
         end
         RESOLVE: begin
            r_d  = (r_q & ~(WP'(CMASK) << sh_c)) | (WP'(slice_sum_c[CHUNK-1:0]) << sh_c);
            cy_d = slice_sum_c[CHUNK];
            k_d  = k_q + KW'(1);
            if (last_chunk_c) begin
               cnt_out_d = cnt_q;
               ovf_out_d = ovf_q;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q       <= '0;
         c_q       <= '0;
         r_q       <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         cnt_out_q <= '0;
         ovf_out_q <= 1'b0;
         cy_q      <= 1'b0;
         k_q       <= '0;
      end else begin
         s_q       <= s_d;
         c_q       <= c_d;
         r_q       <= r_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         cnt_out_q <= cnt_out_d;
         ovf_out_q <= ovf_out_d;
         cy_q      <= cy_d;
         k_q       <= k_d;
      end
   end

   assign out_sum   = r_q[W-1:0];
   assign out_count = cnt_out_q;
   assign out_ovf   = ovf_out_q;

endmodule

// File: doc/csa_accum_ctrl.md
Name: csa_accum_ctrl

Overview:
Sequencer for multi-operand addition built around a carry-save 3:2 compression step. It accepts a stream of N-bit operands over valid/ready and keeps a redundant sum/carry pair, compressing one operand per cycle. On the operand flagged last, it resolves the pair into binary with a chunked carry-propagate pass over several cycles. It then holds the result on a valid/ready output. It sits between operand producers and any consumer needing a binary multi-operand sum.

Parameters:
N, 5, operand width in bits
MAX_OPS, 8, operands per group without overflow; W = N + $clog2(MAX_OPS) (default 8)
CHUNK, 4, bits resolved per cycle in the carry-propagate pass; NCHUNK = ceil(W/CHUNK) (default 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand valid
in_ready  out  1  controller can accept an operand
in_data  in  N  unsigned operand
in_last  in  1  final operand of the current group
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_sum  out  W  binary sum, modulo 2^W
out_count  out  $clog2(MAX_OPS+1)  operands in the group, saturating at MAX_OPS
out_ovf  out  1  more than MAX_OPS operands were accepted
busy  out  1  high in every state except IDLE

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high, ports named clk and rst.
- On reset: state IDLE; S, C, result register, count, ovf and chunk carry all 0.
  - Outputs after reset: out_valid=0, out_sum=0, out_count=0, out_ovf=0, busy=0, in_ready=1.
- Reset mid-operation discards the partial group.
- An operand is accepted on an edge where in_valid && in_ready.
  - in_ready is decoded combinationally from state: 1 in IDLE and ACCUM, else 0.
  - in_data and in_last are ignored while in_ready=0.
- State IDLE: on accept, S <= zero-extended in_data, C <= 0, cnt <= 1, ovf <= 0.
  - Next state is RESOLVE if in_last, else ACCUM.
- State ACCUM: on accept, with X = zero-extended in_data:
  - S <= S^C^X
  - C <= (maj(S,C,X) << 1), truncated to W bits
  - if cnt == MAX_OPS, ovf <= 1 and cnt holds; else cnt++
  - in_last -> RESOLVE
  - cycles with in_valid=0 hold all state; no timeout.
- State RESOLVE (NCHUNK cycles, chunk index k = 0..NCHUNK-1):
  - r[k*CHUNK +: CHUNK] <= S_slice + C_slice + cy; cy <= carry-out of that slice.
  - The top slice is truncated to W bits.
  - After slice NCHUNK-1 -> DONE.
- State DONE:
  - out_valid=1; out_sum, out_count and out_ovf are stable and held.
  - out_ready=1 -> IDLE at the next edge. out_sum/out_count/out_ovf keep their values until the next group resolves.
- Latency: out_valid rises exactly NCHUNK edges after the edge accepting the last operand (2 with defaults).
  - The earliest next operand is accepted on the edge after the output handshake.
- A group of exactly MAX_OPS operands gives ovf=0. The (MAX_OPS+1)th and later operands set ovf=1, and out_sum wraps mod 2^W.
- A single-operand group (in_last on the first operand) is legal: out_sum = in_data, count 1.
- out_valid never depends combinationally on out_ready. in_ready never depends on in_valid.

Decomposition:
- Shared package csa_pkg:
  - state typedef csa_ctrl_state_t {IDLE, ACCUM, RESOLVE, DONE}
  - width helper function csa_acc_width(N, MAX_OPS)
- Derived widths W, NCHUNK and the count width are localparams in the module.
- One sub-module: csa32_compress #(W). Purely combinational bitwise 3:2 compressor (a, b, c -> s, cy shifted left by 1, truncated), instantiated once in the ACCUM datapath.

Test Plan (defaults N=5, MAX_OPS=8, CHUNK=4):
1. Reset, then accept 10 with in_last -> out_valid high 2 edges later; out_sum=10, out_count=1, out_ovf=0; busy 0 after the handshake.
2. Groups {4,6,12} and then {11,2,4}, back-to-back with out_ready=1 -> out_sum 22 then 17, count 3 each; no operand accepted while out_valid=1.
3. Eight operands of 31 -> out_sum=248, count=8, ovf=0. Nine operands of 31 -> out_sum=23 (279 mod 256), count=8, ovf=1.
4. Group {15,15,15}, out_ready low for 5 cycles, in_valid held high with data 7 -> out_sum=45 stable, in_ready=0, the 7 is not accepted; out_ready pulse -> IDLE, then 7 is accepted.
5. Accept 15,15, assert rst mid-ACCUM asynchronously -> all outputs 0 immediately, in_ready=1. Then group {20,0,20} -> out_sum=40, count=3.
6. Group {7, gap of 3 idle cycles, 6, 12 last} -> out_sum=25, count=3; state held during the gaps.
